// File: rtl/dsa_pixel_gather_simd.sv
`timescale 1ns/1ps
// Bilinear neighbour fetch: maps SIMD_WIDTH destination pixels to clamped source neighbours,
// reads four bytes per lane from fixed-latency memory and presents every lane at once.
module dsa_pixel_gather_simd #(
  parameter int ADDR_WIDTH  = 18,
  parameter int SIMD_WIDTH  = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [15:0]               base_x,
  input  logic [15:0]               base_y,
  input  logic [15:0]               inv_scale,
  input  logic [ADDR_WIDTH-1:0]     img_base_addr,
  input  logic [15:0]               img_width,
  input  logic [15:0]               img_height,
  output logic                      mem_read_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [7:0]                mem_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8*SIMD_WIDTH-1:0]   p00,
  output logic [8*SIMD_WIDTH-1:0]   p01,
  output logic [8*SIMD_WIDTH-1:0]   p10,
  output logic [8*SIMD_WIDTH-1:0]   p11,
  output logic [16*SIMD_WIDTH-1:0]  a,
  output logic [16*SIMD_WIDTH-1:0]  b,
  output logic                      busy
);

  localparam int NRD = 4 * SIMD_WIDTH;
  localparam int IW  = $clog2(NRD + 1);

  typedef enum logic [1:0] {IDLE, CALC, FETCH, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            bx_q, bx_d, by_q, by_d, inv_q, inv_d, w_q, w_d, h_q, h_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [IW-1:0]          lane_q, lane_d, iss_q, iss_d, rd_idx_q, rd_idx_d;
  logic [15:0]            x0_q [SIMD_WIDTH], x0_d [SIMD_WIDTH];
  logic [15:0]            x1_q [SIMD_WIDTH], x1_d [SIMD_WIDTH];
  logic [7:0]             fx_q [SIMD_WIDTH], fx_d [SIMD_WIDTH];
  logic [15:0]            y0_q, y0_d, y1_q, y1_d;
  logic [7:0]             fy_q, fy_d;
  logic [7:0]             buf_q [NRD], buf_d [NRD];
  logic [MEM_LATENCY-1:0] sr_vld_q, sr_vld_d;
  logic [IW-1:0]          sr_idx_q [MEM_LATENCY], sr_idx_d [MEM_LATENCY];
  logic                   mem_read_en_q, mem_read_en_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [8*SIMD_WIDTH-1:0]  p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
  logic [16*SIMD_WIDTH-1:0] a_q, a_d, b_q, b_d;

  logic          accept, calc_last, cap_en, fetch_done, issuing;
  logic [IW-1:0] cap_idx;
  logic [23:0]   sx, sy;
  logic [39:0]   cx, cy;
  logic [15:0]   rx, ry;

  // Returns {c0, c1, frac}; at or past the last row/column both taps collapse onto the edge.
  function automatic logic [39:0] clamp_axis(input logic [23:0] s, input logic [15:0] lim);
    logic [15:0] ip;
    ip = s[23:8];
    if (ip >= lim) clamp_axis = {lim, lim, 8'd0};
    else           clamp_axis = {ip, ip + 16'd1, s[7:0]};
  endfunction

  always_comb begin
    accept     = (state_q == IDLE) && req_valid;
    calc_last  = (state_q == CALC) && (lane_q == IW'(SIMD_WIDTH - 1));
    cap_en     = (state_q == FETCH) && sr_vld_q[MEM_LATENCY-1];
    cap_idx    = sr_idx_q[MEM_LATENCY-1];
    fetch_done = cap_en && (cap_idx == IW'(NRD - 1));
    issuing    = (state_q == FETCH) && (iss_q != IW'(NRD));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_valid)  state_d = CALC;
      CALC:  if (calc_last)  state_d = FETCH;
      FETCH: if (fetch_done) state_d = HOLD;
      HOLD:  if (out_ready)  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == HOLD);
  end

  always_comb begin
    bx_d   = accept ? base_x        : bx_q;
    by_d   = accept ? base_y        : by_q;
    inv_d  = accept ? inv_scale     : inv_q;
    base_d = accept ? img_base_addr : base_q;
    w_d    = accept ? ((img_width  == 16'd0) ? 16'd1 : img_width)  : w_q;
    h_d    = accept ? ((img_height == 16'd0) ? 16'd1 : img_height) : h_q;
    lane_d = accept ? '0 : (state_q == CALC) ? lane_q + IW'(1) : lane_q;
    sx = 24'(({16'd0, bx_q} + 32'(lane_q)) * {16'd0, inv_q});
    sy = 24'({16'd0, by_q} * {16'd0, inv_q});
    cx = clamp_axis(sx, w_q - 16'd1);
    cy = clamp_axis(sy, h_q - 16'd1);
    x0_d = x0_q;
    x1_d = x1_q;
    fx_d = fx_q;
    y0_d = y0_q;
    y1_d = y1_q;
    fy_d = fy_q;
    if (state_q == CALC) begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        if (i == int'(lane_q)) begin
          x0_d[i] = cx[39:24];
          x1_d[i] = cx[23:8];
          fx_d[i] = cx[7:0];
        end
      end
      y0_d = cy[39:24];
      y1_d = cy[23:8];
      fy_d = cy[7:0];
    end
  end

  // Read index k: lane k/4, tap k%4 with bit0 selecting x1 and bit1 selecting y1.
  always_comb begin
    rx = 16'd0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      if (i == int'(iss_q) / 4) rx = iss_q[0] ? x1_q[i] : x0_q[i];
    end
    ry            = iss_q[1] ? y1_q : y0_q;
    mem_read_en_d = issuing;
    mem_addr_d    = issuing ? ADDR_WIDTH'(32'(base_q) + {16'd0, ry} * {16'd0, w_q} + {16'd0, rx})
                            : mem_addr_q;
    rd_idx_d      = issuing ? iss_q : rd_idx_q;
    iss_d         = accept ? '0 : issuing ? iss_q + IW'(1) : iss_q;
    sr_vld_d[0]   = mem_read_en_q;
    sr_idx_d[0]   = rd_idx_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      sr_vld_d[i] = sr_vld_q[i-1];
      sr_idx_d[i] = sr_idx_q[i-1];
    end
    buf_d = buf_q;
    if (cap_en) begin
      for (int i = 0; i < NRD; i++) begin
        if (i == int'(cap_idx)) buf_d[i] = mem_data;
      end
    end
  end

  // Results are published only on completion, merging the final captured byte.
  always_comb begin
    p00_d = p00_q;
    p01_d = p01_q;
    p10_d = p10_q;
    p11_d = p11_q;
    a_d   = a_q;
    b_d   = b_q;
    if (fetch_done) begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        p00_d[8*i +: 8]  = buf_d[4*i];
        p01_d[8*i +: 8]  = buf_d[4*i+1];
        p10_d[8*i +: 8]  = buf_d[4*i+2];
        p11_d[8*i +: 8]  = buf_d[4*i+3];
        a_d[16*i +: 16]  = {8'd0, fx_q[i]};
        b_d[16*i +: 16]  = {8'd0, fy_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lane_q        <= '0;
      iss_q         <= '0;
      sr_vld_q      <= '0;
      mem_read_en_q <= 1'b0;
      mem_addr_q    <= '0;
      p00_q         <= '0;
      p01_q         <= '0;
      p10_q         <= '0;
      p11_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      iss_q         <= iss_d;
      sr_vld_q      <= sr_vld_d;
      mem_read_en_q <= mem_read_en_d;
      mem_addr_q    <= mem_addr_d;
      p00_q         <= p00_d;
      p01_q         <= p01_d;
      p10_q         <= p10_d;
      p11_q         <= p11_d;
      a_q           <= a_d;
      b_q           <= b_d;
    end
  end

  always_ff @(posedge clk) begin
    bx_q     <= bx_d;
    by_q     <= by_d;
    inv_q    <= inv_d;
    base_q   <= base_d;
    w_q      <= w_d;
    h_q      <= h_d;
    x0_q     <= x0_d;
    x1_q     <= x1_d;
    fx_q     <= fx_d;
    y0_q     <= y0_d;
    y1_q     <= y1_d;
    fy_q     <= fy_d;
    rd_idx_q <= rd_idx_d;
    sr_idx_q <= sr_idx_d;
    buf_q    <= buf_d;
  end

  assign mem_read_en = mem_read_en_q;
  assign mem_addr    = mem_addr_q;
  assign p00 = p00_q;
  assign p01 = p01_q;
  assign p10 = p10_q;
  assign p11 = p11_q;
  assign a   = a_q;
  assign b   = b_q;

endmodule

// File: tb/tb_dsa_pixel_gather_simd.sv
`timescale 1ns/1ps
// Bench for dsa_pixel_gather_simd: a 4-lane/latency-2 and an 8-lane/latency-4 instance,
// with expected lane results and read addresses queued at issue and checked by monitors.
module tb_dsa_pixel_gather_simd;

  localparam int AW = 18;

  typedef struct packed {
    logic [63:0]  p00, p01, p10, p11;
    logic [127:0] a, b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]   base_x = '0, base_y = '0, inv_scale = '0, img_width = '0, img_height = '0;
  logic [AW-1:0] img_base_addr = '0;
  logic          out_ready = 1'b1;

  logic          req_valid_a = 1'b0, req_ready_a, mem_read_en_a, out_valid_a, busy_a;
  logic [AW-1:0] mem_addr_a;
  logic [7:0]    mem_data_a;
  logic [31:0]   p00_a, p01_a, p10_a, p11_a;
  logic [63:0]   a_a, b_a;

  logic          req_valid_b = 1'b0, req_ready_b, mem_read_en_b, out_valid_b, busy_b;
  logic [AW-1:0] mem_addr_b;
  logic [7:0]    mem_data_b;
  logic [63:0]   p00_b, p01_b, p10_b, p11_b;
  logic [127:0]  a_b, b_b;

  dsa_pixel_gather_simd #(.ADDR_WIDTH(AW), .SIMD_WIDTH(4), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .base_x(base_x), .base_y(base_y), .inv_scale(inv_scale), .img_base_addr(img_base_addr),
    .img_width(img_width), .img_height(img_height), .mem_read_en(mem_read_en_a),
    .mem_addr(mem_addr_a), .mem_data(mem_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .p00(p00_a), .p01(p01_a), .p10(p10_a), .p11(p11_a),
    .a(a_a), .b(b_a), .busy(busy_a));

  dsa_pixel_gather_simd #(.ADDR_WIDTH(AW), .SIMD_WIDTH(8), .MEM_LATENCY(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .base_x(base_x), .base_y(base_y), .inv_scale(inv_scale), .img_base_addr(img_base_addr),
    .img_width(img_width), .img_height(img_height), .mem_read_en(mem_read_en_b),
    .mem_addr(mem_addr_b), .mem_data(mem_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .p00(p00_b), .p01(p01_b), .p10(p10_b), .p11(p11_b),
    .a(a_b), .b(b_b), .busy(busy_b));

  // Memory holds mem[k] = k[7:0]; data emerges MEM_LATENCY cycles after the strobe.
  logic [7:0] pipe_a [2];
  logic [7:0] pipe_b [4];
  always @(posedge clk) begin
    pipe_a[0] <= mem_read_en_a ? mem_addr_a[7:0] : 8'hEE;
    pipe_a[1] <= pipe_a[0];
    pipe_b[0] <= mem_read_en_b ? mem_addr_b[7:0] : 8'hEE;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign mem_data_a = pipe_a[1];
  assign mem_data_b = pipe_b[3];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_a[$], exp_b[$];
  int   addr_qa[$], addr_qb[$];
  int   addr_tmp[32];
  int   lat_ref[2] = '{-1, -1};
  exp_t last_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d, want %0d", name, act, req);
  endtask

  function automatic void axis(input int d, input int inv, input int size,
                               output int c0, output int c1, output int fr);
    longint s;
    int ip, m;
    s  = (longint'(d) * longint'(inv)) & 64'hFFFF_FFFF;
    ip = int'((s >> 8) & 64'hFFFF);
    m  = ((size == 0) ? 1 : size) - 1;
    if (ip >= m) begin c0 = m; c1 = m; fr = 0; end
    else begin c0 = ip; c1 = ip + 1; fr = int'(s & 64'hFF); end
  endfunction

  function automatic exp_t model(input int bx, input int by, input int inv, input int base,
                                 input int w, input int h, input int n);
    exp_t e;
    int x0, x1, fx, y0, y1, fy, we, ad, xs, ys;
    e = '0;
    we = (w == 0) ? 1 : w;
    axis(by, inv, h, y0, y1, fy);
    for (int l = 0; l < n; l++) begin
      axis(bx + l, inv, w, x0, x1, fx);
      e.a[16*l +: 16] = 16'(fx);
      e.b[16*l +: 16] = 16'(fy);
      for (int s = 0; s < 4; s++) begin
        xs = s[0] ? x1 : x0;
        ys = s[1] ? y1 : y0;
        ad = (base + ys * we + xs) & ((1 << AW) - 1);
        addr_tmp[4*l + s] = ad;
        case (s)
          0: e.p00[8*l +: 8] = 8'(ad);
          1: e.p01[8*l +: 8] = 8'(ad);
          2: e.p10[8*l +: 8] = 8'(ad);
          default: e.p11[8*l +: 8] = 8'(ad);
        endcase
      end
    end
    return e;
  endfunction

  // Read-address monitors: every strobe must match the next queued address.
  always @(negedge clk) begin
    if (mem_read_en_a === 1'b1) begin
      if (addr_qa.size() == 0) fail_now("rd_a_unexpected", int'(mem_addr_a), -1);
      else check("rd_addr_a", mem_addr_a, addr_qa.pop_front());
    end
    if (mem_read_en_b === 1'b1) begin
      if (addr_qb.size() == 0) fail_now("rd_b_unexpected", int'(mem_addr_b), -1);
      else check("rd_addr_b", mem_addr_b, addr_qb.pop_front());
    end
  end

  // Result monitors: compare on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_a === 1'b1 && out_ready === 1'b1) begin
      if (exp_a.size() == 0) fail_now("out_a_unexpected", 1, 0);
      else begin
        e = exp_a.pop_front();
        check("a_p00", p00_a, e.p00[31:0]);
        check("a_p01", p01_a, e.p01[31:0]);
        check("a_p10", p10_a, e.p10[31:0]);
        check("a_p11", p11_a, e.p11[31:0]);
        check("a_frac_a", a_a, e.a[63:0]);
        check("a_frac_b", b_a, e.b[63:0]);
      end
    end
    if (out_valid_b === 1'b1 && out_ready === 1'b1) begin
      if (exp_b.size() == 0) fail_now("out_b_unexpected", 1, 0);
      else begin
        e = exp_b.pop_front();
        check("b_p00", p00_b, e.p00);
        check("b_p01", p01_b, e.p01);
        check("b_p10", p10_b, e.p10);
        check("b_p11", p11_b, e.p11);
        check("b_frac_a", a_b, e.a);
        check("b_frac_b", b_b, e.b);
      end
    end
  end

  task automatic drive_fields(input int bx, input int by, input int inv, input int base,
                              input int w, input int h);
    base_x = 16'(bx); base_y = 16'(by); inv_scale = 16'(inv);
    img_base_addr = AW'(base); img_width = 16'(w); img_height = 16'(h);
  endtask

  task automatic run_req(input bit sel, input int bx, input int by, input int inv,
                         input int base, input int w, input int h);
    exp_t e;
    int n, bound, cyc, t, rd, first, last;
    n     = sel ? 8 : 4;
    bound = 5 * n + (sel ? 4 : 2) + 3;
    e     = model(bx, by, inv, base, w, h, n);
    last_exp = e;
    if (sel) begin
      exp_b.push_back(e);
      for (int i = 0; i < 4 * n; i++) addr_qb.push_back(addr_tmp[i]);
    end else begin
      exp_a.push_back(e);
      for (int i = 0; i < 4 * n; i++) addr_qa.push_back(addr_tmp[i]);
    end
    t = 0;
    while ((sel ? req_ready_b : req_ready_a) !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) fail_now("req_ready_timeout", t, 100);
    drive_fields(bx, by, inv, base, w, h);
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    drive_fields(~bx, ~by, ~inv, ~base, ~w, ~h);
    cyc = 0; rd = 0; first = -1; last = -1;
    while ((sel ? out_valid_b : out_valid_a) !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if ((sel ? mem_read_en_b : mem_read_en_a) === 1'b1) begin
        rd++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    n_checks++;
    if (cyc > bound) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, want at most %0d", cyc, bound);
    end
    if (lat_ref[sel] < 0) lat_ref[sel] = cyc;
    else check("latency_repeat", cyc, lat_ref[sel]);
    check("read_count", rd, 4 * n);
    check("read_span", last - first + 1, 4 * n);
    if (out_ready) begin
      t = 0;
      while ((sel ? out_valid_b : out_valid_a) !== 1'b0 && t < 20) begin
        @(posedge clk); #1; t++;
      end
      check("out_valid_fall", t, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd, t;
    exp_t e5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_mem_read_en", mem_read_en_a, 1'b0);
    check("rst_mem_addr", mem_addr_a, 0);
    check("rst_p", {p00_a, p01_a, p10_a, p11_a}, 0);
    check("rst_ab", {a_a, b_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity scale, interior.
    run_req(1'b0, 10, 20, 'h100, 0, 64, 64);
    check("t1_p00_l0", p00_a[7:0], 8'h0A);
    check("t1_p10_l0", p10_a[7:0], 8'h4A);
    check("t1_p11_l3", p11_a[31:24], 8'h4E);
    check("t1_ab", {a_a, b_a}, 0);

    // Half-pixel step: fractions on both axes.
    run_req(1'b0, 3, 5, 'h80, 0, 64, 64);
    check("t2_a_l0", a_a[15:0], 16'h0080);
    check("t2_a_l1", a_a[31:16], 16'h0000);
    check("t2_b_l0", b_a[15:0], 16'h0080);
    check("t2_p00_l0", p00_a[7:0], 8'h81);

    // Right edge clamping with nonzero image base.
    run_req(1'b0, 14, 2, 'h100, 'h1003, 16, 64);
    check("t3_a_l1", a_a[31:16], 16'h0000);
    check("t3_a_l3", a_a[63:48], 16'h0000);
    check("t3_p00_l3", p00_a[31:24], 8'h32);
    check("t3_p01_l1", p01_a[15:8], 8'h32);

    // Zero size behaves as 1x1; bottom edge clamps y.
    run_req(1'b0, 7, 9, 'h300, 'h20, 0, 0);
    check("tz_p11_l2", p11_a[23:16], 8'h20);
    run_req(1'b0, 0, 63, 'h100, 0, 64, 64);
    check("tb_b_l0", b_a[15:0], 16'h0000);

    // Backpressure: outputs hold, no reads, extra requests ignored.
    out_ready = 1'b0;
    run_req(1'b0, 10, 20, 'h100, 0, 64, 64);
    for (int k = 0; k < 10; k++) begin
      check("hold_out_valid", out_valid_a, 1'b1);
      check("hold_req_ready", req_ready_a, 1'b0);
      check("hold_no_read", mem_read_en_a, 1'b0);
      check("hold_p00", p00_a, last_exp.p00[31:0]);
      check("hold_p11", p11_a, last_exp.p11[31:0]);
      if (k >= 2 && k < 6) begin
        drive_fields(1, 2, 'h200, 5, 32, 32);
        req_valid_a = 1'b1;
      end else req_valid_a = 1'b0;
      @(posedge clk); #1;
    end
    req_valid_a = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", out_valid_a, 1'b0);
    check("release_req_ready", req_ready_a, 1'b1);
    check("idle_p01_stable", p01_a, last_exp.p01[31:0]);
    @(posedge clk); #1;
    check("no_queued_req", busy_a, 1'b0);

    // Reset during the third read aborts; the repeat request must be clean.
    e5 = model(3, 5, 'h80, 0, 64, 64, 4);
    for (int i = 0; i < 16; i++) addr_qa.push_back(addr_tmp[i]);
    drive_fields(3, 5, 'h80, 0, 64, 64);
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    rd = 0; t = 0;
    while (rd < 3 && t < 100) begin
      @(posedge clk); #1; t++;
      if (mem_read_en_a === 1'b1) rd++;
    end
    check("t5_third_read", rd, 3);
    rst = 1'b1;
    #1;
    check("t5_rst_read_en", mem_read_en_a, 1'b0);
    check("t5_rst_out_valid", out_valid_a, 1'b0);
    check("t5_rst_busy", busy_a, 1'b0);
    check("t5_rst_p00", p00_a, 0);
    addr_qa.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_req(1'b0, 3, 5, 'h80, 0, 64, 64);
    check("t5_fresh_p00", p00_a, e5.p00[31:0]);
    check("t5_fresh_a", a_a, e5.a[63:0]);

    // Eight lanes, latency four.
    run_req(1'b1, 10, 20, 'h100, 0, 64, 64);
    run_req(1'b1, 5, 7, 'h0C0, 'h100, 40, 30);
    check("t6_a_l7", a_b[127:112], last_exp.a[127:112]);

    repeat (5) @(posedge clk);
    #1;
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);
    check("addr_a_drained", addr_qa.size(), 0);
    check("addr_b_drained", addr_qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
